// File: rtl/chute_brique.sv
// Gravity and stacking engine for the three-column brick game: drops a brick
// on a divided tick, lands it on the stack below, clears full lines, flags game over.
module chute_brique #(
  parameter int ROW_COUNT = 6,
  parameter int TICK_DIV  = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] col,
  output logic [2:0] row,
  output logic [2:0] hauteurGauche,
  output logic [2:0] hauteurCentre,
  output logic [2:0] hauteurDroite,
  output logic       brick_active,
  output logic       landed,
  output logic       game_over,
  output logic [7:0] score,
  output logic [2:0] dbg_state
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPAWN = 3'd1;
  localparam logic [2:0] S_FALL  = 3'd2;
  localparam logic [2:0] S_LAND  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       h_q [0:2];
  logic [2:0]       h_d [0:2];
  logic [1:0]       land_col_q, land_col_d;
  logic [7:0]       score_q, score_d;
  logic             active_q, active_d;
  logic             landed_q, landed_d;
  logic             over_q, over_d;

  logic [1:0] col_eff;
  logic [2:0] h_sel;
  logic       tick;
  logic       at_floor;
  logic       all_filled;

  // Column code 3 is not a real column; it behaves as the centre.
  assign col_eff    = (col == 2'd3) ? 2'd1 : col;
  assign h_sel      = h_q[col_eff];
  assign tick       = (cnt_q == CNT_W'(TICK_DIV - 1));
  // row + h >= ROW_COUNT-1 is the landing test written without a subtraction,
  // so a full or illegal column can never underflow the threshold.
  assign at_floor   = ({1'b0, row_q} + {1'b0, h_sel}) >= 4'(ROW_COUNT - 1);
  assign all_filled = (h_q[0] != 3'd0) && (h_q[1] != 3'd0) && (h_q[2] != 3'd0);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    h_d[0]     = h_q[0];
    h_d[1]     = h_q[1];
    h_d[2]     = h_q[2];
    land_col_d = land_col_q;
    score_d    = score_q;
    active_d   = active_q;
    landed_d   = 1'b0;
    over_d     = over_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SPAWN;
      end

      S_SPAWN: begin
        if (h_sel == 3'(ROW_COUNT)) begin
          state_d  = S_OVER;
          over_d   = 1'b1;
          active_d = 1'b0;
        end else begin
          row_d    = 3'd0;
          cnt_d    = '0;
          active_d = 1'b1;
          state_d  = S_FALL;
        end
      end

      S_FALL: begin
        if (tick) begin
          cnt_d      = '0;
          land_col_d = col_eff;
          if (at_floor) begin
            state_d  = S_LAND;
            landed_d = 1'b1;
            active_d = 1'b0;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The column captured on the landing tick is the one that grows.
      S_LAND: begin
        if (h_q[land_col_q] != 3'(ROW_COUNT)) begin
          h_d[land_col_q] = h_q[land_col_q] + 3'd1;
        end
        state_d = S_CLEAR;
      end

      S_CLEAR: begin
        if (all_filled) begin
          h_d[0] = h_q[0] - 3'd1;
          h_d[1] = h_q[1] - 3'd1;
          h_d[2] = h_q[2] - 3'd1;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end
        state_d = S_SPAWN;
      end

      S_OVER: begin
        if (start) begin
          h_d[0]  = 3'd0;
          h_d[1]  = 3'd0;
          h_d[2]  = 3'd0;
          score_d = 8'd0;
          over_d  = 1'b0;
          state_d = S_SPAWN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      row_q      <= 3'd0;
      cnt_q      <= '0;
      h_q[0]     <= 3'd0;
      h_q[1]     <= 3'd0;
      h_q[2]     <= 3'd0;
      land_col_q <= 2'd0;
      score_q    <= 8'd0;
      active_q   <= 1'b0;
      landed_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      h_q[0]     <= h_d[0];
      h_q[1]     <= h_d[1];
      h_q[2]     <= h_d[2];
      land_col_q <= land_col_d;
      score_q    <= score_d;
      active_q   <= active_d;
      landed_q   <= landed_d;
      over_q     <= over_d;
    end
  end

  assign row           = row_q;
  assign hauteurGauche = h_q[0];
  assign hauteurCentre = h_q[1];
  assign hauteurDroite = h_q[2];
  assign brick_active  = active_q;
  assign landed        = landed_q;
  assign game_over     = over_q;
  assign score         = score_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_chute_brique.sv
// Directed bench for chute_brique: drops bricks through a six-row field with a
// four-cycle tick and checks landing rows, stack heights, clears and game over.
module tb_chute_brique;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] col;
  logic [2:0] row;
  logic [2:0] hauteurGauche;
  logic [2:0] hauteurCentre;
  logic [2:0] hauteurDroite;
  logic       brick_active;
  logic       landed;
  logic       game_over;
  logic [7:0] score;
  logic [2:0] dbg_state;

  logic [15:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  chute_brique #(.ROW_COUNT(6), .TICK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .col          (col),
    .row          (row),
    .hauteurGauche(hauteurGauche),
    .hauteurCentre(hauteurCentre),
    .hauteurDroite(hauteurDroite),
    .brick_active (brick_active),
    .landed       (landed),
    .game_over    (game_over),
    .score        (score),
    .dbg_state    (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] hp(input int g, input int c, input int d);
    return {7'd0, 3'(g), 3'(c), 3'(d)};
  endfunction

  function automatic logic [15:0] h_obs();
    return {7'd0, hauteurGauche, hauteurCentre, hauteurDroite};
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    e = 16'hxxxx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  // Starts a game (from IDLE or OVER) and leaves the first brick at row 0.
  task automatic restart();
    start = 1'b1;
    exp_q.push_back(16'd0);
    exp_q.push_back(hp(0, 0, 0));
    exp_q.push_back(16'd0);
    step();
    start = 1'b0;
    chk("restart_game_over", {15'd0, game_over});
    chk("restart_heights", h_obs());
    chk("restart_score", {8'd0, score});
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd0);
    step();
    chk("spawn_active", {15'd0, brick_active});
    chk("spawn_row", {13'd0, row});
  endtask

  // Waits for the current brick to land; optional col switches after step sw1/sw2.
  task automatic fall(input int exp_row, input int sw1, input logic [1:0] c1,
                      input int sw2, input logic [1:0] c2);
    int n;
    n = 0;
    exp_q.push_back(16'(exp_row));
    exp_q.push_back(16'(4 * (exp_row + 1)));
    exp_q.push_back(16'd0);
    while (!landed && n < 200) begin
      step();
      n++;
      if (n == sw1) col = c1;
      if (n == sw2) col = c2;
    end
    chk("land_row", {13'd0, row});
    chk("land_cycles", 16'(n));
    chk("land_active", {15'd0, brick_active});
  endtask

  // Follows LAND, CLEAR and SPAWN after a landing pulse.
  task automatic post_land(input int lg, input int lc, input int ld,
                           input int cg, input int cc, input int cd,
                           input int sc, input bit next_active);
    exp_q.push_back(hp(lg, lc, ld));
    exp_q.push_back(16'd0);
    step();
    chk("land_heights", h_obs());
    chk("landed_pulse", {15'd0, landed});
    exp_q.push_back(hp(cg, cc, cd));
    exp_q.push_back(16'(sc));
    step();
    chk("clear_heights", h_obs());
    chk("score", {8'd0, score});
    step();
    if (next_active) begin
      exp_q.push_back(16'd1);
      exp_q.push_back(16'd0);
      chk("next_active", {15'd0, brick_active});
      chk("next_row", {13'd0, row});
    end else begin
      exp_q.push_back(16'd1);
      exp_q.push_back(16'd0);
      chk("over_flag", {15'd0, game_over});
      chk("over_active", {15'd0, brick_active});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    col   = 2'd1;
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(16'd0);
    exp_q.push_back(hp(0, 0, 0));
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    chk("reset_row", {13'd0, row});
    chk("reset_heights", h_obs());
    chk("reset_score", {8'd0, score});
    chk("reset_flags", {13'd0, brick_active, landed, game_over});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // first brick in the centre, full fall to the floor
    restart();
    fall(5, 0, 2'd0, 0, 2'd0);
    post_land(0, 1, 0, 0, 1, 0, 0, 1);
    fall(4, 0, 2'd0, 0, 2'd0);
    post_land(0, 2, 0, 0, 2, 0, 0, 1);

    // fill the centre column up to game over
    fall(3, 0, 2'd0, 0, 2'd0);
    post_land(0, 3, 0, 0, 3, 0, 0, 1);
    fall(2, 0, 2'd0, 0, 2'd0);
    post_land(0, 4, 0, 0, 4, 0, 0, 1);
    fall(1, 0, 2'd0, 0, 2'd0);
    post_land(0, 5, 0, 0, 5, 0, 0, 1);
    fall(0, 0, 2'd0, 0, 2'd0);
    post_land(0, 6, 0, 0, 6, 0, 0, 0);
    restart();

    // left column to height 5
    col = 2'd0;
    for (int k = 1; k <= 5; k++) begin
      fall(6 - k, 0, 2'd0, 0, 2'd0);
      post_land(k, 0, 0, k, 0, 0, 0, 1);
    end

    // col wanders 1 -> 2 -> 3; code 3 at the tick means centre
    col = 2'd1;
    fall(5, 6, 2'd2, 12, 2'd3);
    post_land(5, 1, 0, 5, 1, 0, 0, 1);
    col = 2'd2;
    fall(5, 0, 2'd0, 0, 2'd0);
    post_land(5, 1, 1, 4, 0, 0, 1, 1);
    col = 2'd0;
    fall(1, 0, 2'd0, 0, 2'd0);
    post_land(5, 0, 0, 5, 0, 0, 1, 1);

    // asynchronous reset in the middle of a fall
    col = 2'd1;
    repeat (12) step();
    exp_q.push_back(16'd3);
    chk("pre_reset_row", {13'd0, row});
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(16'd0);
    exp_q.push_back(hp(0, 0, 0));
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    chk("async_row", {13'd0, row});
    chk("async_heights", h_obs());
    chk("async_score", {8'd0, score});
    chk("async_active", {15'd0, brick_active});
    repeat (2) step();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    chk("idle_state", {13'd0, dbg_state});
    chk("idle_active", {15'd0, brick_active});

    // left column to 5 again, then steer into it at row 2
    restart();
    col = 2'd0;
    for (int k = 1; k <= 5; k++) begin
      fall(6 - k, 0, 2'd0, 0, 2'd0);
      post_land(k, 0, 0, k, 0, 0, 0, 1);
    end
    col = 2'd1;
    fall(2, 9, 2'd0, 0, 2'd0);
    post_land(6, 0, 0, 6, 0, 0, 0, 0);

    // one brick per column clears a line
    restart();
    col = 2'd0;
    fall(5, 0, 2'd0, 0, 2'd0);
    post_land(1, 0, 0, 1, 0, 0, 0, 1);
    col = 2'd1;
    fall(5, 0, 2'd0, 0, 2'd0);
    post_land(1, 1, 0, 1, 1, 0, 0, 1);
    col = 2'd2;
    fall(5, 0, 2'd0, 0, 2'd0);
    post_land(1, 1, 1, 0, 0, 0, 1, 1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
